// File: rtl/dmem_arb_pkg.sv
// Shared types, port ids and the address legality check for the data-memory arbiter.
// Build option: DMEM_ARB_RR_EN selects round-robin arbitration instead of fixed priority.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_AUX = 1'b1;

  // A word access is legal only when word-aligned and fully inside the memory.
  function automatic logic addr_legal(input logic [63:0] addr, input logic [63:0] mem_bytes);
    return (addr[1:0] == 2'b00) && (addr <= mem_bytes - 64'd4);
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of the two requester ports and the data-memory port around dmem_arbiter.
// slave = arbiter view; master = requesters plus memory (as driven by a testbench or SoC glue).
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req0, req1;
  logic              we0, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic [DATA_W-1:0] rdata0, rdata1;
  logic              ack0, ack1;
  logic              err0, err1;
  logic [ADDR_W-1:0] Daddr;
  logic [DATA_W-1:0] DataIn;
  logic              mRD, mWR;
  logic [DATA_W-1:0] DataOut;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, DataOut,
    output rdata0, rdata1, ack0, ack1, err0, err1, Daddr, DataIn, mRD, mWR
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, DataOut,
    input  rdata0, rdata1, ack0, ack1, err0, err1, Daddr, DataIn, mRD, mWR
  );
endinterface

// File: rtl/dmem_arb_pick.sv
// Combinational winner selection between the two requesters.
// Build option: DMEM_ARB_RR_EN gives simultaneous requests to the port not granted last.
module dmem_arb_pick
  import dmem_arb_pkg::*;
(
  input  logic i_req0,
  input  logic i_req1,
`ifdef DMEM_ARB_RR_EN
  input  logic i_last,
`endif
  output logic o_any,
  output logic o_win
);

  always_comb begin
    o_any = i_req0 | i_req1;
    o_win = PORT_CPU;
`ifdef DMEM_ARB_RR_EN
    if (i_req0 && i_req1) begin
      o_win = ~i_last;
    end else if (i_req1) begin
      o_win = PORT_AUX;
    end
`else
    if (!i_req0 && i_req1) begin
      o_win = PORT_AUX;
    end
`endif
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the big-endian data memory: IDLE -> ACCESS -> RESP per word transaction.
// Build option: DMEM_ARB_RR_EN enables round-robin arbitration (default: port 0 has priority).
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_BYTES = 256
) (
  input logic            CLK,
  input logic            Reset,
  dmem_arbiter_if.slave  bus
);

  state_e            r_state, w_state_nxt;
  logic              r_port, w_port_nxt;
  logic [ADDR_W-1:0] r_daddr, w_daddr_nxt;
  logic [DATA_W-1:0] r_datain, w_datain_nxt;
  logic              r_mrd, w_mrd_nxt;
  logic              r_mwr, w_mwr_nxt;
  logic [DATA_W-1:0] r_rdata0, w_rdata0_nxt;
  logic [DATA_W-1:0] r_rdata1, w_rdata1_nxt;
  logic              r_ack0, w_ack0_nxt;
  logic              r_ack1, w_ack1_nxt;
  logic              r_err0, w_err0_nxt;
  logic              r_err1, w_err1_nxt;
`ifdef DMEM_ARB_RR_EN
  logic              r_last, w_last_nxt;
`endif

  logic              w_any, w_win;
  logic              w_sel_we;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;
  logic              w_legal;
  logic [DATA_W-1:0] w_capture;

  dmem_arb_pick u_pick (
    .i_req0 (bus.req0),
    .i_req1 (bus.req1),
`ifdef DMEM_ARB_RR_EN
    .i_last (r_last),
`endif
    .o_any  (w_any),
    .o_win  (w_win)
  );

  assign w_sel_we    = (w_win == PORT_AUX) ? bus.we1    : bus.we0;
  assign w_sel_addr  = (w_win == PORT_AUX) ? bus.addr1  : bus.addr0;
  assign w_sel_wdata = (w_win == PORT_AUX) ? bus.wdata1 : bus.wdata0;
  assign w_legal     = addr_legal(64'(w_sel_addr), 64'(MEM_BYTES));
  // Stores complete with a zero result; only loads return memory data.
  assign w_capture   = r_mrd ? bus.DataOut : '0;

  always_comb begin
    // NOTE: every next-state variable takes its hold value first, so no branch can infer a latch.
    w_state_nxt  = r_state;
    w_port_nxt   = r_port;
    w_daddr_nxt  = r_daddr;
    w_datain_nxt = r_datain;
    w_mrd_nxt    = r_mrd;
    w_mwr_nxt    = r_mwr;
    w_rdata0_nxt = r_rdata0;
    w_rdata1_nxt = r_rdata1;
    w_ack0_nxt   = r_ack0;
    w_ack1_nxt   = r_ack1;
    w_err0_nxt   = r_err0;
    w_err1_nxt   = r_err1;
`ifdef DMEM_ARB_RR_EN
    w_last_nxt   = r_last;
`endif

    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_port_nxt = w_win;
`ifdef DMEM_ARB_RR_EN
          w_last_nxt = w_win;
`endif
          if (w_legal) begin
            w_state_nxt  = ACCESS;
            w_daddr_nxt  = w_sel_addr;
            w_datain_nxt = w_sel_wdata;
            w_mrd_nxt    = ~w_sel_we;
            w_mwr_nxt    = w_sel_we;
          end else begin
            // Rejected before any strobe: answer straight away with err qualifying ack.
            w_state_nxt = RESP;
            if (w_win == PORT_AUX) begin
              w_ack1_nxt   = 1'b1;
              w_err1_nxt   = 1'b1;
              w_rdata1_nxt = '0;
            end else begin
              w_ack0_nxt   = 1'b1;
              w_err0_nxt   = 1'b1;
              w_rdata0_nxt = '0;
            end
          end
        end
      end

      ACCESS: begin
        w_state_nxt = RESP;
        w_mrd_nxt   = 1'b0;
        w_mwr_nxt   = 1'b0;
        if (r_port == PORT_AUX) begin
          w_rdata1_nxt = w_capture;
          w_ack1_nxt   = 1'b1;
        end else begin
          w_rdata0_nxt = w_capture;
          w_ack0_nxt   = 1'b1;
        end
      end

      RESP: begin
        w_state_nxt = IDLE;
        w_ack0_nxt  = 1'b0;
        w_ack1_nxt  = 1'b0;
        w_err0_nxt  = 1'b0;
        w_err1_nxt  = 1'b0;
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_state  <= IDLE;
      r_port   <= PORT_AUX;
      r_daddr  <= '0;
      r_datain <= '0;
      r_mrd    <= 1'b0;
      r_mwr    <= 1'b0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
      r_ack0   <= 1'b0;
      r_ack1   <= 1'b0;
      r_err0   <= 1'b0;
      r_err1   <= 1'b0;
`ifdef DMEM_ARB_RR_EN
      r_last   <= PORT_AUX;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_port   <= w_port_nxt;
      r_daddr  <= w_daddr_nxt;
      r_datain <= w_datain_nxt;
      r_mrd    <= w_mrd_nxt;
      r_mwr    <= w_mwr_nxt;
      r_rdata0 <= w_rdata0_nxt;
      r_rdata1 <= w_rdata1_nxt;
      r_ack0   <= w_ack0_nxt;
      r_ack1   <= w_ack1_nxt;
      r_err0   <= w_err0_nxt;
      r_err1   <= w_err1_nxt;
`ifdef DMEM_ARB_RR_EN
      r_last   <= w_last_nxt;
`endif
    end
  end

  assign bus.Daddr  = r_daddr;
  assign bus.DataIn = r_datain;
  assign bus.mRD    = r_mrd;
  assign bus.mWR    = r_mwr;
  assign bus.rdata0 = r_rdata0;
  assign bus.rdata1 = r_rdata1;
  assign bus.ack0   = r_ack0;
  assign bus.ack1   = r_ack1;
  assign bus.err0   = r_err0;
  assign bus.err1   = r_err1;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed handshake cases plus random single-port traffic
// compared against a byte-array reference memory. Define DMEM_ARB_RR_EN to check round-robin order.
module tb_dmem_arbiter;

  localparam int unsigned MEM_BYTES = 256;

  logic clk;
  logic rst_n;

  dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_BYTES(256)) dut (
    .CLK   (clk),
    .Reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Physical memory: combinational read, write on falling clock edge.
  logic [7:0] mem     [0:255];
  logic [7:0] ref_mem [0:255];
  logic [7:0] w_a0;
  assign w_a0 = bus.Daddr[7:0];
  assign bus.DataOut = {mem[w_a0], mem[w_a0 + 8'd1], mem[w_a0 + 8'd2], mem[w_a0 + 8'd3]};

  int          n_wr, n_rd;
  logic [31:0] last_wr_addr;

  always @(negedge clk) begin
    if (bus.mWR) begin
      mem[w_a0]        = bus.DataIn[31:24];
      mem[w_a0 + 8'd1] = bus.DataIn[23:16];
      mem[w_a0 + 8'd2] = bus.DataIn[15:8];
      mem[w_a0 + 8'd3] = bus.DataIn[7:0];
      n_wr++;
      last_wr_addr = bus.Daddr;
    end
    if (bus.mRD) n_rd++;
  end

  int n_checks;
  int n_errors;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    logic [7:0] i;
    i = a[7:0];
    return {ref_mem[i], ref_mem[i + 8'd1], ref_mem[i + 8'd2], ref_mem[i + 8'd3]};
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [7:0] i;
    i = a[7:0];
    return {mem[i], mem[i + 8'd1], mem[i + 8'd2], mem[i + 8'd3]};
  endfunction

  function automatic bit is_legal(input logic [31:0] a);
    return (a % 4 == 0) && (a + 4 <= MEM_BYTES);
  endfunction

  task automatic clear_reqs();
    bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
    bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear_reqs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One transaction on a single port; result, latency, strobes and isolation checked against the model.
  task automatic do_txn(input bit p, input bit we, input logic [31:0] addr, input logic [31:0] wd);
    bit          legal, seen;
    logic [31:0] exp_rd, other_rd;
    int          wr0, rd0, lat;
    legal  = is_legal(addr);
    exp_rd = (legal && !we) ? ref_word(addr) : 32'h0;
    @(negedge clk);
    wr0 = n_wr;
    rd0 = n_rd;
    other_rd = p ? bus.rdata0 : bus.rdata1;
    if (p) begin
      bus.req1 = 1'b1; bus.we1 = we; bus.addr1 = addr; bus.wdata1 = wd;
    end else begin
      bus.req0 = 1'b1; bus.we0 = we; bus.addr0 = addr; bus.wdata0 = wd;
    end
    seen = 1'b0;
    lat  = 0;
    while (!seen && lat < 8) begin
      @(posedge clk); #1;
      lat++;
      if (p ? bus.ack1 : bus.ack0) seen = 1'b1;
    end
    check("ack_seen", 64'(seen), 64'd1);
    check("latency", 64'(lat), legal ? 64'd2 : 64'd1);
    check("err", 64'(p ? bus.err1 : bus.err0), 64'(!legal));
    check("rdata", 64'(p ? bus.rdata1 : bus.rdata0), 64'(exp_rd));
    check("other_ack_err", 64'(p ? (bus.ack0 | bus.err0) : (bus.ack1 | bus.err1)), 64'd0);
    check("other_rdata", 64'(p ? bus.rdata0 : bus.rdata1), 64'(other_rd));
    if (p) bus.req1 = 1'b0; else bus.req0 = 1'b0;
    @(posedge clk); #1;
    check("ack_pulse", 64'(p ? (bus.ack1 | bus.err1) : (bus.ack0 | bus.err0)), 64'd0);
    @(negedge clk);
    check("wr_strobes", 64'(n_wr - wr0), 64'(legal && we));
    check("rd_strobes", 64'(n_rd - rd0), 64'(legal && !we));
    if (legal && we) begin
      ref_mem[addr[7:0]]        = wd[31:24];
      ref_mem[addr[7:0] + 8'd1] = wd[23:16];
      ref_mem[addr[7:0] + 8'd2] = wd[15:8];
      ref_mem[addr[7:0] + 8'd3] = wd[7:0];
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int          rd0, wr0, k, acks0, acks1;
    bit [3:0]    order, exp_order;
    bit          got_ack;
    logic [31:0] a, d;

    n_checks = 0; n_errors = 0; n_wr = 0; n_rd = 0; last_wr_addr = '0;
    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'h00;
      ref_mem[i] = 8'h00;
    end
    rst_n = 1'b0;
    clear_reqs();
    repeat (2) @(negedge clk);
    check("rst_Daddr", 64'(bus.Daddr), 64'd0);
    check("rst_strobes", 64'({bus.mRD, bus.mWR}), 64'd0);
    check("rst_ack_err", 64'({bus.ack0, bus.ack1, bus.err0, bus.err1}), 64'd0);
    check("rst_rdata", 64'({bus.rdata0, bus.rdata1}), 64'd0);
    rst_n = 1'b1;

    // Port 1 load after reset; port 0 stays quiet.
    do_txn(1'b1, 1'b0, 32'h0, 32'h0);
    check("p0_rdata_quiet", 64'(bus.rdata0), 64'd0);

    // Store then load on port 0.
    do_txn(1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
    check("store_addr", 64'(last_wr_addr), 64'h10);
    check("store_mem", 64'(mem_word(32'h10)), 64'hDEADBEEF);
    do_txn(1'b0, 1'b0, 32'h10, 32'h0);
    check("load_back", 64'(bus.rdata0), 64'hDEADBEEF);

    // Rejected accesses: misaligned and beyond the last full word.
    do_txn(1'b0, 1'b0, 32'h13, 32'h0);
    do_txn(1'b1, 1'b1, 32'hFE, 32'hCAFEF00D);
    check("oor_mem", 64'(mem_word(32'hFC)), 64'd0);
    do_txn(1'b1, 1'b0, 32'hFC, 32'h0);

    // Both ports hold load requests; port 0 wants two, port 1 wants two.
    apply_reset();
    @(negedge clk);
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 32'h10;
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 32'h04;
    acks0 = 0; acks1 = 0; k = 0; order = '0;
    for (int c = 0; c < 40 && k < 4; c++) begin
      @(posedge clk); #1;
      if (bus.ack0) begin
        order[k] = 1'b0; k++; acks0++;
        check("both_rdata0", 64'(bus.rdata0), 64'(ref_word(32'h10)));
        if (acks0 == 2) bus.req0 = 1'b0;
      end else if (bus.ack1) begin
        order[k] = 1'b1; k++; acks1++;
        check("both_rdata1", 64'(bus.rdata1), 64'(ref_word(32'h04)));
        if (acks1 == 2) bus.req1 = 1'b0;
      end
    end
    clear_reqs();
    check("both_count", 64'(k), 64'd4);
`ifdef DMEM_ARB_RR_EN
    exp_order = 4'b1010;
`else
    exp_order = 4'b1100;
`endif
    check("grant_order", 64'(order), 64'(exp_order));

    // Port 1 withdraws in the cycle port 0 is granted.
    apply_reset();
    @(negedge clk);
    rd0 = n_rd;
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 32'h10;
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 32'h14;
    @(posedge clk); #1;
    bus.req1 = 1'b0;
    check("wd_grant_addr", 64'({bus.mRD, bus.Daddr}), 64'({1'b1, 32'h10}));
    acks0 = 0; acks1 = 0;
    for (int c = 0; c < 8; c++) begin
      if (bus.ack0) begin acks0++; bus.req0 = 1'b0; end
      if (bus.ack1) acks1++;
      @(posedge clk); #1;
    end
    clear_reqs();
    check("wd_ack0", 64'(acks0), 64'd1);
    check("wd_ack1", 64'(acks1), 64'd0);
    check("wd_reads", 64'(n_rd - rd0), 64'd1);

    // Reset during ACCESS of a store, before the falling edge.
    @(negedge clk);
    wr0 = n_wr;
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 32'h20; bus.wdata0 = 32'h12345678;
    @(posedge clk); #1;
    check("rst_mid_mwr_on", 64'(bus.mWR), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_mwr_off", 64'(bus.mWR), 64'd0);
    clear_reqs();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    got_ack = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (bus.ack0 | bus.ack1) got_ack = 1'b1;
    end
    check("rst_mid_no_ack", 64'(got_ack), 64'd0);
    check("rst_mid_no_write", 64'(n_wr - wr0), 64'd0);
    do_txn(1'b0, 1'b0, 32'h20, 32'h0);

    // Random single-port traffic against the reference memory.
    for (int t = 0; t < 40; t++) begin
      case ($urandom_range(0, 3))
        0, 1:    a = {22'd0, 8'($urandom_range(0, 63)), 2'b00};
        2:       a = {24'd0, 8'($urandom_range(0, 255))} | 32'h1;
        default: a = 32'($urandom_range(253, 400));
      endcase
      d = $urandom;
      do_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, d);
    end
    for (int i = 0; i < 256; i += 4) begin
      if (mem_word(32'(i)) !== ref_word(32'(i)))
        check("final_mem", 64'(mem_word(32'(i))), 64'(ref_word(32'(i))));
    end
    check("final_mem_sample", 64'(mem_word(32'h10)), 64'(ref_word(32'h10)));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
